// File: rtl/com_op_code_pkg.sv
// Shared op-code map, issuer state encoding and small helpers for the
// firmware-side op-code issuer.
package com_op_code_pkg;

    localparam logic [3:0] OP_W_RESET         = 4'd0;
    localparam logic [3:0] OP_W_CFG_STATIC_0  = 4'd1;
    localparam logic [3:0] OP_R_CFG_STATIC_0  = 4'd2;
    localparam logic [3:0] OP_W_CFG_STATIC_1  = 4'd3;
    localparam logic [3:0] OP_R_CFG_STATIC_1  = 4'd4;
    localparam logic [3:0] OP_W_CFG_ARRAY_0   = 4'd5;
    localparam logic [3:0] OP_R_CFG_ARRAY_0   = 4'd6;
    localparam logic [3:0] OP_W_CFG_ARRAY_1   = 4'd7;
    localparam logic [3:0] OP_R_CFG_ARRAY_1   = 4'd8;
    localparam logic [3:0] OP_W_CFG_ARRAY_2   = 4'd9;
    localparam logic [3:0] OP_R_CFG_ARRAY_2   = 4'd10;
    localparam logic [3:0] OP_R_DATA_ARRAY_0  = 4'd11;
    localparam logic [3:0] OP_R_DATA_ARRAY_1  = 4'd12;
    localparam logic [3:0] OP_W_STATUS_CLEAR  = 4'd13;
    localparam logic [3:0] OP_W_EXECUTE       = 4'd14;
    localparam logic [3:0] OP_INVALID         = 4'd15;

    localparam int unsigned NUM_OP = 15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } issuer_state_t;

    // Codes whose target finishes within the single strobe cycle.
    function automatic logic is_self_completing(input logic [3:0] op);
        return (op == OP_W_RESET) || (op == OP_W_STATUS_CLEAR);
    endfunction

endpackage

// File: rtl/com_op_code_timeout_cnt.sv
// Loadable up-counter with clear/enable; tc flags the last allowed
// WAIT_DONE cycle (count == TIMEOUT_CYCLES-1).
module com_op_code_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic [TO_W-1:0] load_value,
    input  logic            enable,
    output logic            tc
);

    logic [TO_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/com_op_code_issuer.sv
// Accepts one command at a time, validates dev_id/op code, drives the
// one-hot op-code strobe and waits for completion or timeout.
module com_op_code_issuer #(
    parameter logic [3:0]  DEV_ID         = 4'h0,
    parameter int unsigned NUM_OP         = com_op_code_pkg::NUM_OP,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 16
) (
    input  logic              fw_axi_clk,
    input  logic              fw_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_dev_id,
    input  logic [3:0]        cmd_op_code,
    input  logic              op_done,
    output logic              fw_dev_id_enable,
    output logic [NUM_OP-1:0] fw_op_code,
    output logic              busy,
    input  logic              sts_clear,
    output logic              sts_done,
    output logic              sts_err_dev_id,
    output logic              sts_err_op,
    output logic              sts_err_timeout
);

    import com_op_code_pkg::*;

    issuer_state_t state_q, state_d;
    logic [3:0]    op_q;
    logic          cmd_ready_q, cmd_ready_d;
    logic          accept, dev_ok, op_ok, to_tc;
    logic          set_done, set_err_dev, set_err_op, set_err_to;

    assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign dev_ok = (cmd_dev_id == DEV_ID);
    assign op_ok  = (32'(cmd_op_code) < NUM_OP);

    com_op_code_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout_cnt (
        .clk        (fw_axi_clk),
        .rst_n      (fw_rst_n),
        .clear      (state_q == ISSUE),
        .load       (1'b0),
        .load_value ('0),
        .enable     (state_q == WAIT_DONE),
        .tc         (to_tc)
    );

    always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_q         <= IDLE;
            op_q            <= '0;
            cmd_ready_q     <= 1'b1;
            sts_done        <= 1'b0;
            sts_err_dev_id  <= 1'b0;
            sts_err_op      <= 1'b0;
            sts_err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            if (accept) begin
                op_q <= cmd_op_code;
            end
            // A set event in the same cycle as sts_clear takes priority.
            sts_done        <= set_done    | (sts_done        & ~sts_clear);
            sts_err_dev_id  <= set_err_dev | (sts_err_dev_id  & ~sts_clear);
            sts_err_op      <= set_err_op  | (sts_err_op      & ~sts_clear);
            sts_err_timeout <= set_err_to  | (sts_err_timeout & ~sts_clear);
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        set_done    = 1'b0;
        set_err_dev = 1'b0;
        set_err_op  = 1'b0;
        set_err_to  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!dev_ok) begin
                        set_err_dev = 1'b1;
                    end else if (!op_ok) begin
                        set_err_op = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (is_self_completing(op_q)) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (op_done) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                end else if (to_tc) begin
                    state_d    = IDLE;
                    set_err_to = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready is withheld for one cycle after any handshake, dropped or not.
        cmd_ready_d = (state_d == IDLE) && !accept;
    end

    // Outputs decode registered state only; cmd_* never reaches a strobe.
    always_comb begin
        busy             = (state_q != IDLE);
        fw_dev_id_enable = busy;
        cmd_ready        = cmd_ready_q;
        fw_op_code       = '0;
        for (int i = 0; i < int'(NUM_OP); i++) begin
            fw_op_code[i] = busy && (op_q == 4'(i));
        end
    end

endmodule

// File: tb/tb_com_op_code_issuer.sv
// Self-checking bench for com_op_code_issuer: directed test-plan steps
// followed by randomized commands against a transaction-level model.
module tb_com_op_code_issuer;

    localparam logic [3:0]  DEV = 4'hA;
    localparam int unsigned T   = 8;
    localparam int unsigned NOP = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_dev_id, cmd_op_code;
    logic        op_done;
    logic        fw_dev_id_enable;
    logic [14:0] fw_op_code;
    logic        busy;
    logic        sts_clear;
    logic        sts_done, sts_err_dev_id, sts_err_op, sts_err_timeout;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int exp_acc = 0;
    logic exp_done, exp_dev, exp_op, exp_to;

    com_op_code_issuer #(
        .DEV_ID         (DEV),
        .NUM_OP         (NOP),
        .TIMEOUT_CYCLES (T),
        .TO_W           (16)
    ) dut (
        .fw_axi_clk       (clk),
        .fw_rst_n         (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_dev_id       (cmd_dev_id),
        .cmd_op_code      (cmd_op_code),
        .op_done          (op_done),
        .fw_dev_id_enable (fw_dev_id_enable),
        .fw_op_code       (fw_op_code),
        .busy             (busy),
        .sts_clear        (sts_clear),
        .sts_done         (sts_done),
        .sts_err_dev_id   (sts_err_dev_id),
        .sts_err_op       (sts_err_op),
        .sts_err_timeout  (sts_err_timeout)
    );

    always #5 clk = ~clk;

    // Inputs are stable around negedge, so this sees the same handshake as the DUT.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) n_acc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sts(input string tag);
        check({tag, "_done"}, 32'(sts_done),        32'(exp_done));
        check({tag, "_dev"},  32'(sts_err_dev_id),  32'(exp_dev));
        check({tag, "_op"},   32'(sts_err_op),      32'(exp_op));
        check({tag, "_to"},   32'(sts_err_timeout), 32'(exp_to));
    endtask

    // Transaction-level model: strobe length in cycles (0 = dropped).
    // d is the strobe-relative cycle op_done is raised; outside 1..T it never is.
    function automatic int exp_len(input logic [3:0] dev, input logic [3:0] op, input int d);
        if (dev != DEV || int'(op) >= int'(NOP)) return 0;
        if (op == 4'd0 || op == 4'd13) return 1;
        if (d >= 1 && d <= int'(T)) return d + 1;
        return int'(T) + 1;
    endfunction

    task automatic do_cmd(input logic [3:0] dev, input logic [3:0] op, input int d,
                          input logic hold, input logic clr_at_end);
        int   len;
        int   waitc;
        logic sc;
        logic [14:0] oh;
        len = exp_len(dev, op, d);
        sc  = (op == 4'd0 || op == 4'd13);
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 50) begin
            step();
            waitc++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_dev_id  = dev;
        cmd_op_code = op;
        exp_acc++;
        step();
        cmd_valid = hold;
        if (len == 0) begin
            if (dev != DEV) exp_dev = 1'b1;
            else            exp_op  = 1'b1;
            check("drop_strobe", 32'(fw_op_code), 32'd0);
            check("drop_busy",   32'(busy),       32'd0);
            check("drop_ready",  32'(cmd_ready),  32'd0);
            check_sts("drop_sts");
            step();
            check("drop_ready_back", 32'(cmd_ready), 32'd1);
        end else begin
            oh = 15'd1;
            oh = oh << op;
            for (int k = 0; k < len; k++) begin
                check("strobe",    32'(fw_op_code),       32'(oh));
                check("dev_en",    32'(fw_dev_id_enable), 32'd1);
                check("busy",      32'(busy),             32'd1);
                check("ready_low", 32'(cmd_ready),        32'd0);
                op_done   = !sc && (k == d);
                sts_clear = clr_at_end && (k == len - 1);
                step();
                op_done   = 1'b0;
                sts_clear = 1'b0;
            end
            if (clr_at_end) {exp_done, exp_dev, exp_op, exp_to} = 4'b0000;
            if (sc || (d >= 1 && d <= int'(T))) exp_done = 1'b1;
            else                                 exp_to   = 1'b1;
            check("end_strobe", 32'(fw_op_code),       32'd0);
            check("end_dev_en", 32'(fw_dev_id_enable), 32'd0);
            check("end_busy",   32'(busy),             32'd0);
            check("end_ready",  32'(cmd_ready),        32'd1);
            check_sts("end_sts");
        end
    endtask

    task automatic clear_sts();
        sts_clear = 1'b1;
        step();
        sts_clear = 1'b0;
        {exp_done, exp_dev, exp_op, exp_to} = 4'b0000;
        check_sts("clear");
    endtask

    initial begin
        logic [3:0] r_dev, r_op;
        int         r_d;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_dev_id = '0; cmd_op_code = '0;
        op_done = 1'b0; sts_clear = 1'b0;
        {exp_done, exp_dev, exp_op, exp_to} = 4'b0000;
        #12;
        check("rst_ready",  32'(cmd_ready),        32'd1);
        check("rst_busy",   32'(busy),             32'd0);
        check("rst_strobe", 32'(fw_op_code),       32'd0);
        check("rst_dev_en", 32'(fw_dev_id_enable), 32'd0);
        check_sts("rst");
        step();
        rst_n = 1'b1;
        step();

        // Execute with op_done 5 cycles after the strobe: 6 strobe cycles.
        do_cmd(DEV, 4'd14, 5, 1'b0, 1'b0);
        // Self-completing reset code: single-cycle strobe.
        do_cmd(DEV, 4'd0, 0, 1'b0, 1'b0);
        // Wrong device, then invalid op code.
        do_cmd(DEV ^ 4'h1, 4'd5, 3, 1'b0, 1'b0);
        do_cmd(DEV, 4'd15, 3, 1'b0, 1'b0);
        clear_sts();
        // Timeout: op_done never raised, then op_done on the terminal cycle.
        do_cmd(DEV, 4'd11, 0, 1'b0, 1'b0);
        clear_sts();
        do_cmd(DEV, 4'd11, int'(T), 1'b0, 1'b0);
        // op_done while idle is ignored.
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        check("idle_done_busy", 32'(busy), 32'd0);
        check_sts("idle_done");

        // Reset three cycles into WAIT_DONE of op 6.
        cmd_valid = 1'b1; cmd_dev_id = DEV; cmd_op_code = 4'd6;
        exp_acc++;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        check("pre_rst_strobe", 32'(fw_op_code), 32'h0040);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_strobe", 32'(fw_op_code),       32'd0);
        check("async_rst_dev_en", 32'(fw_dev_id_enable), 32'd0);
        check("async_rst_busy",   32'(busy),             32'd0);
        step(); step();
        rst_n = 1'b1;
        {exp_done, exp_dev, exp_op, exp_to} = 4'b0000;
        step();
        check_sts("post_rst");
        do_cmd(DEV, 4'd7, 0, 1'b0, 1'b0);

        // Valid held through the command; sts_clear collides with op_done.
        do_cmd(DEV, 4'd14, 4, 1'b1, 1'b1);
        do_cmd(DEV, 4'd3, 2, 1'b0, 1'b0);

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            r_dev = ($urandom_range(0, 4) == 0) ? (DEV ^ 4'($urandom_range(1, 15))) : DEV;
            r_op  = 4'($urandom_range(0, 15));
            r_d   = int'($urandom_range(1, T + 3));
            do_cmd(r_dev, r_op, r_d, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) clear_sts();
        end

        step();
        check("accept_count", 32'(n_acc), 32'(exp_acc));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/com_op_code_issuer.md
Name: com_op_code_issuer

Overview:
Firmware-side command issuer. It produces the device-enable and one-hot op-code strobes that the op-code decoder gates into the test-block datapath.
- Accepts one encoded command at a time (target dev_id and 4-bit op code) from the software register bank via a valid/ready handshake.
- Checks the dev_id and the op code, drives the matching strobe, then waits for completion or timeout.
- Reports sticky status bits back to the register bank.

Parameters:
DEV_ID, 4'h0, dev_id this instance answers to
NUM_OP, 15, number of op-code strobes (codes 0..NUM_OP-1 valid)
TIMEOUT_CYCLES, 1024, max WAIT_DONE cycles before timeout; must be >=2
TO_W, 16, timeout counter width; 2**TO_W > TIMEOUT_CYCLES

Ports:
fw_axi_clk  in  1  block clock
fw_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  issuer can accept command
cmd_dev_id  in  4  target device id
cmd_op_code  in  4  encoded op code
op_done  in  1  completion pulse from addressed sub-block
fw_dev_id_enable  out  1  device enable to decoder
fw_op_code  out  NUM_OP  one-hot strobe vector; bit n = op code n
busy  out  1  command in flight
sts_clear  in  1  clears sticky status bits
sts_done  out  1  sticky: last command completed
sts_err_dev_id  out  1  sticky: dev_id mismatch, command dropped
sts_err_op  out  1  sticky: op code >= NUM_OP, command dropped
sts_err_timeout  out  1  sticky: op_done not seen within TIMEOUT_CYCLES

Op-code map (package constants): 0 w_reset, 1 w_cfg_static_0, 2 r_cfg_static_0, 3 w_cfg_static_1, 4 r_cfg_static_1, 5 w_cfg_array_0, 6 r_cfg_array_0, 7 w_cfg_array_1, 8 r_cfg_array_1, 9 w_cfg_array_2, 10 r_cfg_array_2, 11 r_data_array_0, 12 r_data_array_1, 13 w_status_clear, 14 w_execute, 15 invalid.

Behaviour:
Reset:
- State IDLE, cmd_ready=1.
- All other outputs 0; timeout counter 0.
- Asserting fw_rst_n low mid-command aborts it immediately: all strobes drop asynchronously and no status bit is set.

States: IDLE, ISSUE, WAIT_DONE.

IDLE:
- cmd_ready=1.
- On cmd_valid&cmd_ready, register dev_id and op code, set cmd_ready=0, then:
  - dev_id != DEV_ID -> sts_err_dev_id=1, stay IDLE, no strobe.
  - op code >= NUM_OP -> sts_err_op=1, stay IDLE, no strobe.
  - Otherwise -> ISSUE.
- cmd_ready returns to 1 the cycle after a dropped command.

ISSUE (exactly 1 cycle):
- fw_dev_id_enable=1, fw_op_code[op]=1, busy=1.
- Self-completing codes 0 (w_reset) and 13 (w_status_clear): go to IDLE, set sts_done. Strobe width is 1 cycle.
- All other codes: go to WAIT_DONE, clear counter.

WAIT_DONE:
- Strobe and fw_dev_id_enable stay asserted, busy=1; counter increments each cycle.
- op_done=1 -> IDLE next cycle, set sts_done, drop strobe.
- Counter reaches TIMEOUT_CYCLES-1 with no op_done -> IDLE, set sts_err_timeout, drop strobe.
- op_done on the same cycle as the timeout: done wins, no timeout flag.

General rules:
- Latency: strobe is asserted in the cycle after the accepting handshake.
- fw_op_code is always one-hot or zero; never more than one bit set.
- fw_dev_id_enable=busy.
- cmd_ready=0 whenever busy; commands are not queued.
- op_done in IDLE is ignored.
- sts_clear clears all sticky bits next cycle. If it coincides with a set event, the set wins.
- Registered outputs only; no combinational path from cmd_* to strobes.

Decomposition:
- Package com_op_code_pkg holds:
  - the op-code localparams above (OP_W_RESET=4'd0 ... OP_W_EXECUTE=4'd14);
  - NUM_OP;
  - state enum typedef issuer_state_t {IDLE, ISSUE, WAIT_DONE};
  - function is_self_completing(op).
- One natural sub-module: com_op_code_timeout_cnt. It is a loadable up-counter with clear/enable and a terminal-count flag at TIMEOUT_CYCLES-1.

Test Plan:
- Reset, then cmd dev_id=DEV_ID op=14 with op_done 5 cycles after the strobe -> fw_op_code=15'h4000 for 6 cycles, then 0; sts_done=1, busy=0, cmd_ready=1.
- cmd op=0 -> fw_op_code=15'h0001 for exactly 1 cycle, no op_done needed; sts_done=1.
- cmd dev_id=DEV_ID^1 op=5 -> no strobe, sts_err_dev_id=1. Separately op=15 -> no strobe, sts_err_op=1; cmd_ready high again after 1 cycle.
- cmd op=11 with op_done never asserted, TIMEOUT_CYCLES=8 -> strobe 0x0800 for 9 cycles (ISSUE+8), then sts_err_timeout=1. Repeat with op_done on the terminal cycle -> sts_done=1, sts_err_timeout=0.
- fw_rst_n low 3 cycles into WAIT_DONE of op=6 -> fw_op_code=0 and fw_dev_id_enable=0 immediately; all status bits 0 after release.
- cmd_valid held continuously while busy, plus sts_clear coinciding with op_done -> exactly one accept per completion; sts_done reads 1 after the collision.
